simon_byte_loader: RTL
======================

# simon_byte_loader

Byte-stream front end for the SIMON 48/96 core. Assembles plaintext/ciphertext blocks and keys from an 8-bit valid/ready stream, holds completed words in registers, and presents them to the core through its newData/loadData and newKey/loadKey handshakes. It sits directly upstream of the core and drives its BLOCK, KEY, newData, newKey and enc_dec inputs.

## Interface
- N, 24, word width in bits; 2N and M*N must be multiples of 8
- M, 4, key words
- clk  in  1  system clock, all state on rising edge
- R  in  1  asynchronous, active-high reset
- in_byte  in  8  stream byte, most-significant byte of the word first
- in_valid  in  1  in_byte valid
- in_key  in  1  qualifies in_byte: 1 = key byte, 0 = block byte
- in_dec  in  1  direction for the block; sampled with the last block byte
- in_ready  out  1  byte accepted at the edge where in_valid && in_ready
- BLOCK  out  [1:0][N-1:0]  held block to the core
- KEY  out  [M-1:0][N-1:0]  held key to the core
- enc_dec  out  1  1 = encrypt, 0 = decrypt, held with BLOCK
- newData  out  1  block offer to the core
- newKey  out  1  key offer to the core
- loadData  in  1  core has taken BLOCK
- loadKey  in  1  core has taken KEY

## Operation
- Two independent assembly paths, each with a byte counter and a shift register: block (BB = 2N/8 bytes, 6 at default) and key (KB = M*N/8 bytes, 12 at default).
- Shifting: each accepted byte is shifted in at the LSB end, so after BB bytes the first byte sits in BLOCK[1][N-1:N-8]. The key path works the same way, with the first byte in KEY[M-1] MSB.
- Each path has one holding register and a pending flag, which drive BLOCK/KEY and newData/newKey.
- Block transfer: when the last block byte is accepted and the block holding register is not pending, the assembled value, together with enc_dec = ~in_dec, is copied to the holding register. The counter returns to 0 and block pending is set.
- Block wait: if the holding register is still pending, the assembly register stays full. block-ready is low until the transfer happens, at the first edge after pending clears.
- Key transfer: the same rules apply to the key path.
- in_ready = in_key ? key-ready : block-ready, combinational. A path is ready when its counter is below full.
- Offers: newKey = key pending. newData = block pending && !key pending, so a key completed before a block is always delivered first.
- Release: pending clears at the edge where loadData (or loadKey) is sampled high while the matching new* output is high.
- Gap rule: a transfer is allowed only when pending was low at the start of that cycle. new* therefore drops for at least one cycle between consecutive words.
- Stability: BLOCK, KEY and enc_dec change only on a transfer. They are stable for the whole time the matching new* is high.
- Ignored loads: loadData while newData is low has no effect. The same applies to loadKey.

## Timing
- Reset values: BLOCK = 0, KEY = 0, enc_dec = 1, newData = 0, newKey = 0, counters 0, pending 0. in_ready = 1 once R is low.
- Reset mid-operation discards all partial and held words immediately (asynchronous). There is no deferred offer after reset.
- Latency: the last byte is accepted at edge k. The transfer happens at edge k, and newKey, or newData if no key is pending, is high from just after edge k.
- Release: loadData high at edge j clears newData after edge j.
- Back-to-back: the next held word can be transferred at edge j+1 at the earliest, so new* is low for at least one cycle.
- Simultaneous events: last-byte accept and load of the same path at the same edge release the old word only. Transfer occurs at the next edge, and the byte is not lost.
- Bytes of the other path are accepted independently on any cycle.

## Test plan
- Key load: R pulse, then key bytes 1A 19 18 12 11 10 0A 09 08 02 01 00 with in_key = 1. Required: KEY[3] = 1A1918, KEY[2] = 121110, KEY[1] = 0A0908, KEY[0] = 020100, and newKey high the cycle after the 12th byte. loadKey high for one cycle drops newKey at the next edge.
- Block load: bytes 72 69 63 20 64 6E, in_key = 0, in_dec = 0. Required: BLOCK = 48'h72696320646E, enc_dec = 1, newData high. With no loadData, a further 6 bytes are accepted, then in_ready goes low.
- Ordering: key bytes complete, then block bytes complete, with neither load asserted. Required: newData stays 0 while newKey = 1. After loadKey, newData rises with the held block.
- Back-to-back: five blocks (72696320646E, A8D5F7DE0123, 5BC92D014567, F2B48D4589AB, 567F11DECDEF), with loadData answered 2 cycles after newData each time. Required: each block is offered in order, BLOCK is stable while newData is high, and newData is low for at least 1 cycle between offers.
- Edge collision: the 6th byte of block 2 is accepted at the same edge as loadData for block 1. Required: newData low for exactly 1 cycle, then block 2 offered. No byte is dropped or duplicated.
- Reset mid-stream: R asserted after 3 block bytes and 5 key bytes. Required: all outputs return to their reset values asynchronously. The next 6 block bytes form a complete block on their own.

Source files
------------

// File: rtl/simon_byte_loader.sv
// Byte-stream front end for the SIMON core: assembles blocks and keys from an 8-bit
// valid/ready stream and offers them through the core's newData/newKey handshakes.
module simon_byte_loader #(
   parameter int unsigned N = 24,
   parameter int unsigned M = 4
) (
   input  logic                 clk,
   input  logic                 R,
   input  logic [7:0]           in_byte,
   input  logic                 in_valid,
   input  logic                 in_key,
   input  logic                 in_dec,
   output logic                 in_ready,
   output logic [1:0][N-1:0]    BLOCK,
   output logic [M-1:0][N-1:0]  KEY,
   output logic                 enc_dec,
   output logic                 newData,
   output logic                 newKey,
   input  logic                 loadData,
   input  logic                 loadKey
);

   localparam int unsigned BW  = 2 * N;
   localparam int unsigned KW  = M * N;
   localparam int unsigned BB  = BW / 8;
   localparam int unsigned KB  = KW / 8;
   localparam int unsigned BCW = $clog2(BB + 1);
   localparam int unsigned KCW = $clog2(KB + 1);
   localparam logic [BCW-1:0] BlkFull = BCW'(BB);
   localparam logic [KCW-1:0] KeyFull = KCW'(KB);

   logic [BCW-1:0] blk_cnt_q, blk_cnt_d;
   logic [BW-1:0]  blk_sr_q, blk_sr_d, blk_hold_q, blk_hold_d;
   logic           blk_dec_q, blk_dec_d, enc_q, enc_d, blk_pend_q, blk_pend_d;
   logic [KCW-1:0] key_cnt_q, key_cnt_d;
   logic [KW-1:0]  key_sr_q, key_sr_d, key_hold_q, key_hold_d;
   logic           key_pend_q, key_pend_d;
   logic           blk_rdy, key_rdy, blk_acc, key_acc;

   always_comb begin
      blk_rdy  = blk_cnt_q < BlkFull;
      key_rdy  = key_cnt_q < KeyFull;
      in_ready = in_key ? key_rdy : blk_rdy;
      blk_acc  = in_valid && !in_key && blk_rdy;
      key_acc  = in_valid && in_key && key_rdy;
      // A pending key always goes first, so it masks the block offer.
      newKey   = key_pend_q;
      newData  = blk_pend_q && !key_pend_q;
   end

   always_comb begin
      blk_sr_d   = blk_sr_q;
      blk_cnt_d  = blk_cnt_q;
      blk_dec_d  = blk_dec_q;
      blk_hold_d = blk_hold_q;
      enc_d      = enc_q;
      blk_pend_d = blk_pend_q;
      if (blk_acc) begin
         blk_sr_d  = {blk_sr_q[BW-9:0], in_byte};
         blk_cnt_d = blk_cnt_q + 1'b1;
         if (blk_cnt_q == BlkFull - 1'b1) blk_dec_d = in_dec;
      end
      if (newData && loadData) blk_pend_d = 1'b0;
      // Transfer only if pending was already low at the start of this cycle.
      if ((blk_cnt_d == BlkFull) && !blk_pend_q) begin
         blk_hold_d = blk_sr_d;
         enc_d      = ~blk_dec_d;
         blk_cnt_d  = '0;
         blk_pend_d = 1'b1;
      end
   end

   always_comb begin
      key_sr_d   = key_sr_q;
      key_cnt_d  = key_cnt_q;
      key_hold_d = key_hold_q;
      key_pend_d = key_pend_q;
      if (key_acc) begin
         key_sr_d  = {key_sr_q[KW-9:0], in_byte};
         key_cnt_d = key_cnt_q + 1'b1;
      end
      if (newKey && loadKey) key_pend_d = 1'b0;
      if ((key_cnt_d == KeyFull) && !key_pend_q) begin
         key_hold_d = key_sr_d;
         key_cnt_d  = '0;
         key_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         blk_cnt_q  <= '0;
         blk_sr_q   <= '0;
         blk_hold_q <= '0;
         blk_dec_q  <= 1'b0;
         enc_q      <= 1'b1;
         blk_pend_q <= 1'b0;
         key_cnt_q  <= '0;
         key_sr_q   <= '0;
         key_hold_q <= '0;
         key_pend_q <= 1'b0;
      end else begin
         blk_cnt_q  <= blk_cnt_d;
         blk_sr_q   <= blk_sr_d;
         blk_hold_q <= blk_hold_d;
         blk_dec_q  <= blk_dec_d;
         enc_q      <= enc_d;
         blk_pend_q <= blk_pend_d;
         key_cnt_q  <= key_cnt_d;
         key_sr_q   <= key_sr_d;
         key_hold_q <= key_hold_d;
         key_pend_q <= key_pend_d;
      end
   end

   assign BLOCK   = blk_hold_q;
   assign KEY     = key_hold_q;
   assign enc_dec = enc_q;

endmodule
